// File: rtl/stream_word_checker_pkg.sv
// Shared types, default widths and helpers for the stream word checker.
package stream_word_checker_pkg;

   localparam int unsigned DEF_BYTE_W         = 8;
   localparam int unsigned DEF_WORD_BYTES     = 4;
   localparam int unsigned DEF_PREAMBLE_BYTES = 16;
   localparam int unsigned DEF_FIFO_DEPTH     = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 100;
   localparam int unsigned DEF_CNT_W          = 16;

   // Byte placement inside a packed word
   localparam bit LSB_FIRST_ORDER = 1'b0;
   localparam bit MSB_FIRST_ORDER = 1'b1;

   // Loader phase: discarding preamble, or packing payload bytes
   typedef enum logic {
      ST_PREAMBLE = 1'b0,
      ST_PACK     = 1'b1
   } load_state_e;

   // Bits needed to hold values 0..n-1 (at least one bit)
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_word_checker_fifo.sv
// Synchronous FIFO holding expected words; head is the oldest entry.
module sync_fifo
   import stream_word_checker_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned AW = cnt_bits(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer update; index bits address storage, top bit tracks wrap
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset since empty gates the head
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/stream_word_checker.sv
// Byte-stream packer and write-data checker: drops a preamble, packs bytes into
// expected words, and compares them against the words a config writer emits.
module stream_word_checker
   import stream_word_checker_pkg::*;
#(
   parameter int unsigned BYTE_W         = DEF_BYTE_W,
   parameter int unsigned WORD_BYTES     = DEF_WORD_BYTES,
   parameter bit          MSB_FIRST      = MSB_FIRST_ORDER,
   parameter int unsigned PREAMBLE_BYTES = DEF_PREAMBLE_BYTES,
   parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = DEF_CNT_W
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         enable_i,
   input  logic [BYTE_W-1:0]            in_data_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [BYTE_W*WORD_BYTES-1:0] write_data_i,
   input  logic                         word_write_strobe_i,
   output logic [BYTE_W*WORD_BYTES-1:0] expected_word_o,
   output logic                         mismatch_o,
   output logic                         underflow_o,
   output logic                         timeout_o,
   output logic                         error_o,
   output logic [CNT_W-1:0]             match_count_o,
   output logic [CNT_W-1:0]             mismatch_count_o
);

   localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
   localparam int unsigned BI_W   = cnt_bits(WORD_BYTES);
   localparam int unsigned PC_W   = cnt_bits(PREAMBLE_BYTES + 1);
   localparam int unsigned TC_W   = cnt_bits(TIMEOUT_CYCLES + 1);
   localparam logic [BI_W-1:0] LAST_IDX = BI_W'(WORD_BYTES - 1);
   localparam load_state_e RESET_STATE = (PREAMBLE_BYTES == 0) ? ST_PACK : ST_PREAMBLE;

   load_state_e       state_q, state_d;
   logic [PC_W-1:0]   pre_cnt_q, pre_cnt_d;
   logic [BI_W-1:0]   byte_idx_q;
   logic [WORD_W-1:0] accum_q;
   logic [WORD_W-1:0] word_asm;
   logic [TC_W-1:0]   stall_cnt_q;
   logic              mismatch_seen_q;

   logic              preamble_done;
   logic              accept;
   logic              pack_accept;
   logic              last_byte;
   logic              push;
   logic              pop;
   logic              stall;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WORD_W-1:0] fifo_head;

   assign preamble_done = (state_q == ST_PACK);
   assign last_byte     = (byte_idx_q == LAST_IDX);
   assign in_ready_o    = enable_i & ~(fifo_full & last_byte & preamble_done);
   assign accept        = in_valid_i & in_ready_o;
   assign pack_accept   = accept & preamble_done;
   assign push          = pack_accept & last_byte;
   assign pop           = word_write_strobe_i & ~fifo_empty;
   assign stall         = in_valid_i & enable_i & ~in_ready_o;

   assign expected_word_o = fifo_empty ? '0 : fifo_head;
   assign error_o         = mismatch_seen_q | underflow_o | timeout_o;

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (push),
      .push_data_i (word_asm),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (fifo_head)
   );

   // Loader phase register and preamble down-counter
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= RESET_STATE;
         pre_cnt_q <= PC_W'(PREAMBLE_BYTES);
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
      end
   end

   // Next phase: leave preamble once the last discarded byte is accepted
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      if ((state_q == ST_PREAMBLE) && accept) begin
         pre_cnt_d = pre_cnt_q - PC_W'(1);
         if (pre_cnt_q == PC_W'(1)) state_d = ST_PACK;
      end
   end

   // Word under assembly including the byte on the input this cycle
   always_comb begin
      word_asm = accum_q;
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
         if (byte_idx_q == BI_W'(k)) begin
            if (MSB_FIRST) word_asm[WORD_W-1-k*BYTE_W -: BYTE_W] = in_data_i;
            else           word_asm[k*BYTE_W +: BYTE_W]          = in_data_i;
         end
      end
   end

   // Byte index and partial word; cleared when a word is pushed
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         byte_idx_q <= '0;
         accum_q    <= '0;
      end else if (pack_accept) begin
         byte_idx_q <= last_byte ? '0 : byte_idx_q + BI_W'(1);
         accum_q    <= last_byte ? '0 : word_asm;
      end
   end

   // Compare on strobe: saturating counters, mismatch pulse, sticky flags
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mismatch_o       <= 1'b0;
         underflow_o      <= 1'b0;
         mismatch_seen_q  <= 1'b0;
         match_count_o    <= '0;
         mismatch_count_o <= '0;
      end else begin
         mismatch_o <= 1'b0;
         if (pop) begin
            if (fifo_head == write_data_i) begin
               if (match_count_o != '1) match_count_o <= match_count_o + CNT_W'(1);
            end else begin
               mismatch_o      <= 1'b1;
               mismatch_seen_q <= 1'b1;
               if (mismatch_count_o != '1) mismatch_count_o <= mismatch_count_o + CNT_W'(1);
            end
         end
         if (word_write_strobe_i && fifo_empty) underflow_o <= 1'b1;
      end
   end

   // Stall watchdog: consecutive offered-but-refused cycles
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
         timeout_o   <= 1'b0;
      end else if (stall) begin
         if (stall_cnt_q != TC_W'(TIMEOUT_CYCLES)) stall_cnt_q <= stall_cnt_q + TC_W'(1);
         if (stall_cnt_q == TC_W'(TIMEOUT_CYCLES - 1)) timeout_o <= 1'b1;
      end else begin
         stall_cnt_q <= '0;
      end
   end

endmodule
